rv32i_pipe_regs: RTL and testbench
==================================

# rv32i_pipe_regs

Parametrised pipeline-register chain that carries a control word and a data word per instruction through `DEPTH` in-order stages of the RV32I datapath. It replaces the single fixed stage register pair with a generic bank that adds:
- per-stage valid bits;
- stall propagation with automatic bubble insertion;
- per-stage flush;
- occupancy and bubble-count status.

It sits between the decode logic and the writeback stage, and each stage's contents feed that stage's datapath logic.

## Interface
Parameters:
- `DEPTH`, 4, number of pipeline stages (≥2); stage 0 is youngest, stage DEPTH-1 is oldest.
- `CW_W`, 32, control-word width in bits (an all-zero control word is a NOP: no regfile load, no memory access).
- `DW_W`, 256, data-word width in bits.
- `CNT_W`, 32, bubble-counter width.

Ports (clock is `clk`; reset is `rst`, synchronous and active-high):
- `clk`  in  1  clock, all state updates on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `in_valid`  in  1  new instruction presented to stage 0.
- `in_cw`  in  CW_W  control word of the new instruction.
- `in_dw`  in  DW_W  data word of the new instruction.
- `in_ready`  out  1  stage 0 accepts its input this cycle.
- `stall`  in  DEPTH  bit i holds stage i this cycle.
- `flush`  in  DEPTH  bit i forces stage i to a bubble on the next edge.
- `out_valid`  out  DEPTH  valid bit of each stage register.
- `out_cw`  out  DEPTH*CW_W  stage i's control word at bits [i*CW_W +: CW_W].
- `out_dw`  out  DEPTH*DW_W  stage i's data word at bits [i*DW_W +: DW_W].
- `occupancy`  out  $clog2(DEPTH+1)  number of set `out_valid` bits.
- `bubble_cnt`  out  CNT_W  saturating count of cycles with the oldest stage empty.

## Operation
- **Hold chain (combinational):**
  - hold[DEPTH-1] = stall[DEPTH-1].
  - hold[i] = stall[i] | hold[i+1] for i < DEPTH-1.
  - A stall at stage k therefore freezes stages 0..k.
- **`in_ready`** = !hold[0]. It is independent of `in_valid` and `flush`.
- **Per-stage next state**, evaluated in priority order:
  1. `rst`: valid=0, cw=0, dw=0.
  2. flush[i]: valid=0, cw=0, dw=0 (bubble). This overrides hold and any incoming instruction.
  3. hold[i]: retain the current valid, cw and dw.
  4. i==0: load in_valid, plus in_cw/in_dw if in_valid; if !in_valid, load the bubble (zeros).
  5. i>0 and hold[i-1]: load a bubble. This is the bubble inserted below a stalled stage.
  6. i>0 otherwise: load stage i-1's valid, cw and dw.
- **Retirement:** contents of stage DEPTH-1 leave the chain whenever !hold[DEPTH-1]. No retire handshake exists; the consumer samples the outputs.
- **Input acceptance:** if flush[0] and in_ready are both high, the input is consumed and discarded. This supports the fetch redirect on a mispredict.
- **Bubble definition:** valid=0 with all-zero cw and dw. Stage logic may rely on a zero control word meaning NOP.
- **`occupancy`:** popcount of the valid registers, combinational from registers only.
- **`bubble_cnt`:**
  - Increments by 1 on each edge where out_valid[DEPTH-1]==0 before the edge.
  - Saturates at 2^CNT_W-1.
  - Cleared to 0 by rst and otherwise never cleared.

## Timing
- Reset values: out_valid=0, out_cw=0, out_dw=0, occupancy=0, bubble_cnt=0. in_ready=1 during reset when stall==0.
- Latency: an instruction accepted at edge t appears in stage i at edge t+i (visible in cycle t+1+i) with no stalls. Stage DEPTH-1 is reached after DEPTH edges.
- Throughput: one instruction per cycle when stall==0.
- Stall/flush take effect on the same edge they are sampled. There is no registered delay on hold.
- Simultaneous stall[k] and flush[k]: stage k becomes a bubble. Stages below k still freeze, and stage k+1 receives a bubble.
- Reset mid-stream discards all in-flight contents on the next edge; the counter restarts at 0.

## Test plan
- **Reset/flow:** DEPTH=4, assert rst 2 cycles, then feed in_cw=1,2,3,4… each cycle with stall=flush=0. Required response:
  - out_valid=0 and bubble_cnt=0 during reset;
  - cw=1 appears at stage 3 exactly 4 edges after acceptance, followed by 2,3,4 on consecutive cycles;
  - occupancy reaches 4.
- **Mid-stage stall:** full pipe (stages 0..3 = 8,7,6,5), stall=4'b0010 for 2 cycles. Required response:
  - stages 0,1 hold 8,7 and in_ready=0;
  - stage 2 shows 6 then a bubble (cw=0, valid=0);
  - stage 3 shows 6 then the bubble;
  - occupancy drops to 2.
- **Flush:** full pipe (stages 0..3 = 8,7,6,5), flush=4'b0011 with in_valid=1, in_cw=9. Next cycle required:
  - stages 0,1 are bubbles and the input is dropped;
  - stage 2 holds 7 and stage 3 holds 6;
  - in_ready stays 1.
- **Stall+flush same stage:** stall=flush=4'b0100 on a full pipe. Required response:
  - stage 2 becomes a bubble;
  - stages 0,1 hold;
  - stage 3 gets a bubble;
  - in_ready=0.
- **Counter saturation:** CNT_W=4, in_valid=0 for 20 cycles after reset. Required response: bubble_cnt counts 0..15 and stays at 15. A following rst returns it to 0.

Source files
------------

// File: rtl/rv32i_pipe_regs.sv
// Purpose : parametrised in-order pipeline-register bank (valid + control word + data word per stage)
//           with stall propagation, automatic bubble insertion, per-stage flush and status counters.
// Latency : instruction accepted at edge t sits in stage i after edge t+i; no extra registering of hold.
// Backpressure: a stall at stage k freezes stages 0..k; in_ready = !hold[0], independent of in_valid/flush.
// Ports   : clk/rst (sync, active-high); in_valid/in_cw/in_dw/in_ready (stage-0 input);
//           stall/flush (one bit per stage); out_valid/out_cw/out_dw (flattened stage contents,
//           stage i at [i*W +: W]); occupancy (popcount of valids); bubble_cnt (saturating count
//           of cycles with the oldest stage empty).
module rv32i_pipe_regs #(
  parameter int DEPTH = 4,
  parameter int CW_W  = 32,
  parameter int DW_W  = 256,
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [CW_W-1:0]            in_cw,
  input  logic [DW_W-1:0]            in_dw,
  output logic                       in_ready,
  input  logic [DEPTH-1:0]           stall,
  input  logic [DEPTH-1:0]           flush,
  output logic [DEPTH-1:0]           out_valid,
  output logic [DEPTH*CW_W-1:0]      out_cw,
  output logic [DEPTH*DW_W-1:0]      out_dw,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           bubble_cnt
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]           r_valid;
  logic [DEPTH-1:0][CW_W-1:0] r_cw;
  logic [DEPTH-1:0][DW_W-1:0] r_dw;
  logic [CNT_W-1:0]           r_bubble_cnt;
  logic [DEPTH-1:0]           w_hold;
  logic [OCC_W-1:0]           w_occ;

  // Hold ripples from the oldest stage toward stage 0: anything behind a stalled
  // stage must also freeze or it would overwrite the stalled instruction.
  always_comb begin
    logic w_acc;
    w_acc  = 1'b0;
    w_hold = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      w_acc     = w_acc | stall[i];
      w_hold[i] = w_acc;
    end
  end

  assign in_ready = !w_hold[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_cw    <= '0;
      r_dw    <= '0;
    end else begin
      // Stage 0: flush discards whatever is presented, which lets fetch redirect
      // on a mispredict without an extra cycle.
      if (flush[0]) begin
        r_valid[0] <= 1'b0;
        r_cw[0]    <= '0;
        r_dw[0]    <= '0;
      end else if (!w_hold[0]) begin
        r_valid[0] <= in_valid;
        r_cw[0]    <= in_valid ? in_cw : '0;
        r_dw[0]    <= in_valid ? in_dw : '0;
      end

      for (int i = 1; i < DEPTH; i++) begin
        if (flush[i]) begin
          r_valid[i] <= 1'b0;
          r_cw[i]    <= '0;
          r_dw[i]    <= '0;
        end else if (!w_hold[i]) begin
          if (w_hold[i-1]) begin
            // Stage behind us is frozen: advance with a bubble so the same
            // instruction is not duplicated downstream.
            r_valid[i] <= 1'b0;
            r_cw[i]    <= '0;
            r_dw[i]    <= '0;
          end else begin
            r_valid[i] <= r_valid[i-1];
            r_cw[i]    <= r_cw[i-1];
            r_dw[i]    <= r_dw[i-1];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (!r_valid[DEPTH-1] && (r_bubble_cnt != {CNT_W{1'b1}})) begin
      r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  always_comb begin
    w_occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ = w_occ + OCC_W'(r_valid[i]);
    end
  end

  assign out_valid  = r_valid;
  assign out_cw     = r_cw;
  assign out_dw     = r_dw;
  assign occupancy  = w_occ;
  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_rv32i_pipe_regs.sv
module tb_rv32i_pipe_regs;

  localparam int DEPTH = 4;
  localparam int CW_W  = 32;
  localparam int DW_W  = 256;
  localparam int CNT_W = 4;
  localparam int OCC_W = $clog2(DEPTH+1);

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic [CW_W-1:0]       in_cw;
  logic [DW_W-1:0]       in_dw;
  logic                  in_ready;
  logic [DEPTH-1:0]      stall;
  logic [DEPTH-1:0]      flush;
  logic [DEPTH-1:0]      out_valid;
  logic [DEPTH*CW_W-1:0] out_cw;
  logic [DEPTH*DW_W-1:0] out_dw;
  logic [OCC_W-1:0]      occupancy;
  logic [CNT_W-1:0]      bubble_cnt;

  int errors = 0;
  int checks = 0;
  bit sb_en  = 1'b0;

  typedef struct packed {
    logic [CW_W-1:0] cw;
    logic [DW_W-1:0] dw;
  } exp_t;
  exp_t sb_q[$];

  rv32i_pipe_regs #(.DEPTH(DEPTH), .CW_W(CW_W), .DW_W(DW_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_cw     (in_cw),
    .in_dw     (in_dw),
    .in_ready  (in_ready),
    .stall     (stall),
    .flush     (flush),
    .out_valid (out_valid),
    .out_cw    (out_cw),
    .out_dw    (out_dw),
    .occupancy (occupancy),
    .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW_W-1:0] dw_of(logic [CW_W-1:0] c);
    return {(DW_W/32){c ^ 32'hA5A5_0000}};
  endfunction

  function automatic logic [CW_W-1:0] cw_at(int i);
    return out_cw[i*CW_W +: CW_W];
  endfunction

  function automatic logic [DW_W-1:0] dw_at(int i);
    return out_dw[i*DW_W +: DW_W];
  endfunction

  task automatic check(string tag, logic [DW_W-1:0] obs, logic [DW_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves stages 0..3 holding 8,7,6,5.
  task automatic fill_full();
    stall = '0;
    flush = '0;
    for (int k = 5; k <= 8; k++) begin
      in_valid = 1'b1;
      in_cw    = CW_W'(k);
      in_dw    = dw_of(CW_W'(k));
      step();
    end
    in_valid = 1'b0;
    in_cw    = '0;
    in_dw    = '0;
  endtask

  // Retirement monitor: every valid instruction in the oldest stage must match
  // the next expected entry, in order.
  initial begin
    forever begin
      @(negedge clk);
      if (sb_en && out_valid[DEPTH-1]) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_retire", {224'd0, cw_at(DEPTH-1)}, '1);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_retire_cw", {224'd0, cw_at(DEPTH-1)}, {224'd0, e.cw});
          check("sb_retire_dw", dw_at(DEPTH-1), e.dw);
        end
      end
    end
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_cw    = '0;
    in_dw    = '0;
    stall    = '0;
    flush    = '0;

    // Reset
    step();
    step();
    check("rst_valid", {252'd0, out_valid}, '0);
    check("rst_cw", {128'd0, out_cw}, '0);
    check("rst_dw_s3", dw_at(3), '0);
    check("rst_occ", {253'd0, occupancy}, '0);
    check("rst_bcnt", {252'd0, bubble_cnt}, '0);
    check("rst_in_ready", {255'd0, in_ready}, 256'd1);

    // Streaming flow with the scoreboard on the retire side
    rst   = 1'b0;
    sb_en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      exp_t e;
      in_valid = 1'b1;
      in_cw    = CW_W'(k);
      in_dw    = dw_of(CW_W'(k));
      e.cw     = CW_W'(k);
      e.dw     = dw_of(CW_W'(k));
      sb_q.push_back(e);
      step();
      if (k == 3) check("flow_s3_empty_before_4_edges", {255'd0, out_valid[3]}, '0);
      if (k == 4) begin
        check("flow_s3_cw_after_4_edges", {224'd0, cw_at(3)}, 256'd1);
        check("flow_occ_full", {253'd0, occupancy}, 256'd4);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    sb_en = 1'b0;
    check("flow_sb_left", 256'(sb_q.size()), 256'd3);
    check("flow_bcnt", {252'd0, bubble_cnt}, 256'd4);
    check("flow_s0_cw", {224'd0, cw_at(0)}, 256'd8);
    check("flow_s3_cw", {224'd0, cw_at(3)}, 256'd5);
    sb_q.delete();

    // Mid-stage stall: stages 0,1 freeze, bubble slides out through 2 and 3
    stall    = 4'b0010;
    in_valid = 1'b1;
    in_cw    = 32'd9;
    in_dw    = dw_of(32'd9);
    #1;
    check("stall_in_ready", {255'd0, in_ready}, '0);
    step();
    check("stall1_s0", {224'd0, cw_at(0)}, 256'd8);
    check("stall1_s1", {224'd0, cw_at(1)}, 256'd7);
    check("stall1_s2_cw", {224'd0, cw_at(2)}, '0);
    check("stall1_s2_valid", {255'd0, out_valid[2]}, '0);
    check("stall1_s3_cw", {224'd0, cw_at(3)}, 256'd6);
    check("stall1_occ", {253'd0, occupancy}, 256'd3);
    step();
    check("stall2_s0", {224'd0, cw_at(0)}, 256'd8);
    check("stall2_s1", {224'd0, cw_at(1)}, 256'd7);
    check("stall2_s3_cw", {224'd0, cw_at(3)}, '0);
    check("stall2_s3_valid", {255'd0, out_valid[3]}, '0);
    check("stall2_s3_dw", dw_at(3), '0);
    check("stall2_occ", {253'd0, occupancy}, 256'd2);
    check("stall2_in_ready", {255'd0, in_ready}, '0);

    // Flush of stages 0,1 drops the presented input
    fill_full();
    flush    = 4'b0011;
    in_valid = 1'b1;
    in_cw    = 32'd9;
    in_dw    = dw_of(32'd9);
    #1;
    check("flush_in_ready_pre", {255'd0, in_ready}, 256'd1);
    step();
    check("flush_valid", {252'd0, out_valid}, 256'b1100);
    check("flush_s0_cw", {224'd0, cw_at(0)}, '0);
    check("flush_s0_dw", dw_at(0), '0);
    check("flush_s1_cw", {224'd0, cw_at(1)}, '0);
    check("flush_s2_cw", {224'd0, cw_at(2)}, 256'd7);
    check("flush_s3_cw", {224'd0, cw_at(3)}, 256'd6);
    check("flush_in_ready", {255'd0, in_ready}, 256'd1);
    flush    = '0;
    in_valid = 1'b0;
    in_cw    = '0;
    in_dw    = '0;
    step();
    check("flush_dropped_s1", {224'd0, cw_at(1)}, '0);

    // Stall and flush on the same stage
    fill_full();
    stall = 4'b0100;
    flush = 4'b0100;
    #1;
    check("sf_in_ready_pre", {255'd0, in_ready}, '0);
    step();
    check("sf_s0", {224'd0, cw_at(0)}, 256'd8);
    check("sf_s1", {224'd0, cw_at(1)}, 256'd7);
    check("sf_s2_cw", {224'd0, cw_at(2)}, '0);
    check("sf_s3_cw", {224'd0, cw_at(3)}, '0);
    check("sf_valid", {252'd0, out_valid}, 256'b0011);
    check("sf_in_ready", {255'd0, in_ready}, '0);
    stall = '0;
    flush = '0;

    // Counter saturation
    rst = 1'b1;
    step();
    step();
    check("sat_rst", {252'd0, bubble_cnt}, '0);
    rst = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      step();
      check($sformatf("sat_n%0d", n), {252'd0, bubble_cnt}, 256'(n > 15 ? 15 : n));
    end
    rst = 1'b1;
    step();
    check("sat_rst_again", {252'd0, bubble_cnt}, '0);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
